// File: rtl/vx_find_first_pipe_if.sv
// Handshake bundle for vx_find_first_pipe: request side (valid/ready/data/mask)
// and result side (valid/ready/data/index/found).
interface vx_find_first_pipe_if #(
    parameter int N     = 8,
    parameter int DATAW = 1,
    parameter int LOGN  = (N > 1) ? $clog2(N) : 1
);
    logic                       valid_in;
    logic                       ready_in;
    logic [N-1:0][DATAW-1:0]    data_in;
    logic [N-1:0]               mask_in;
    logic                       valid_out;
    logic                       ready_out;
    logic [DATAW-1:0]           data_out;
    logic [LOGN-1:0]            index_out;
    logic                       found_out;

    modport master (
        output valid_in, data_in, mask_in, ready_out,
        input  ready_in, valid_out, data_out, index_out, found_out
    );

    modport slave (
        input  valid_in, data_in, mask_in, ready_out,
        output ready_in, valid_out, data_out, index_out, found_out
    );
endinterface

// File: rtl/vx_find_first_pipe.sv
// Pipelined priority selector: picks the first set lane (fixed or rotating priority)
// through a binary tree with a register stage every PIPE_EVERY levels.
module vx_find_first_pipe #(
    parameter int N           = 8,
    parameter int DATAW       = 1,
    parameter int REVERSE     = 0,
    parameter int ROUND_ROBIN = 0,
    parameter int PIPE_EVERY  = 1,
    parameter int LOGN        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_find_first_pipe_if.slave   bus
);
    localparam int LEAVES = 1 << LOGN;
    localparam int S      = (PIPE_EVERY == 0) ? 0 : (LOGN + PIPE_EVERY - 1) / PIPE_EVERY;
    localparam int VLD_W  = (S == 0) ? 1 : S;
    localparam logic [LOGN-1:0] LAST_LANE = LOGN'(N - 1);
    localparam logic [LOGN-1:0] PTR_RST   = (REVERSE != 0) ? LAST_LANE : '0;

    typedef struct packed {
        logic              found;
        logic [LOGN-1:0]   idx;
        logic [DATAW-1:0]  data;
    } node_t;

    // Higher-priority (left) child wins whenever it found something.
    function automatic node_t merge(input node_t hi, input node_t lo);
        return hi.found ? hi : lo;
    endfunction

    function automatic bit level_is_reg(input int l);
        if (PIPE_EVERY == 0) return 1'b0;
        return (((l + 1) % PIPE_EVERY) == 0) || (l == LOGN - 1);
    endfunction

    function automatic int level_stage(input int l);
        if (PIPE_EVERY == 0) return 0;
        return (l + PIPE_EVERY) / PIPE_EVERY - 1;
    endfunction

    logic [LOGN-1:0]             rr_ptr_q, rr_ptr_d;
    logic [LOGN-1:0]             base_ptr;
    node_t [LEAVES-1:0]          leaves;
    node_t [LOGN:0][LEAVES-1:0]  lvl;
    logic [VLD_W-1:0]            stg_load;
    logic [VLD_W-1:0]            stg_vin;
    logic                        fire_out;
    node_t                       root;

    // Rotation: leaf j holds the j-th lane in search order, tagged with its real index.
    always_comb begin
        logic [LOGN-1:0] lane;
        lane     = '0;
        base_ptr = (ROUND_ROBIN != 0) ? rr_ptr_q : PTR_RST;
        leaves   = '0;
        for (int j = 0; j < N; j++) begin
            if (REVERSE != 0) lane = LOGN'((int'(base_ptr) - j + N) % N);
            else              lane = LOGN'((int'(base_ptr) + j) % N);
            if (bus.mask_in[lane]) begin
                leaves[j].found = 1'b1;
                leaves[j].idx   = lane;
                leaves[j].data  = bus.data_in[lane];
            end
        end
    end

    assign lvl[0] = leaves;

    for (genvar l = 0; l < LOGN; l++) begin : g_lvl
        localparam int W = LEAVES >> (l + 1);
        node_t [W-1:0]      red_n;
        node_t [W-1:0]      out_n;
        node_t [LEAVES-1:0] lvl_n;

        always_comb begin
            red_n = '0;
            for (int i = 0; i < W; i++) red_n[i] = merge(lvl[l][2*i], lvl[l][2*i+1]);
        end

        if (level_is_reg(l)) begin : g_reg
            localparam int K = level_stage(l);
            node_t [W-1:0] node_q, node_d;

            always_comb begin
                node_d = node_q;
                if (stg_load[K] && stg_vin[K]) node_d = red_n;
            end

            // Stage K boundary
            always_ff @(posedge clk or posedge reset) begin
                if (reset) node_q <= '0;
                else       node_q <= node_d;
            end

            assign out_n = node_q;
        end else begin : g_comb
            assign out_n = red_n;
        end

        always_comb begin
            lvl_n        = '0;
            lvl_n[W-1:0] = out_n;
        end

        assign lvl[l+1] = lvl_n;
    end

    if (S == 0) begin : g_ctl_comb
        assign stg_load      = '0;
        assign stg_vin       = '0;
        assign bus.valid_out = bus.valid_in;
        assign bus.ready_in  = bus.ready_out;
    end else begin : g_ctl_pipe
        logic [S-1:0] vld_q, vld_d;

        // A stage may load when empty or when everything ahead of it moves this cycle.
        always_comb begin
            logic nxt_load;
            nxt_load = fire_out;
            stg_vin  = VLD_W'({vld_q, bus.valid_in});
            stg_load = '0;
            vld_d    = vld_q;
            for (int k = S - 1; k >= 0; k--) begin
                nxt_load    = !vld_q[k] || nxt_load;
                stg_load[k] = nxt_load;
                if (nxt_load) vld_d[k] = stg_vin[k];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) vld_q <= '0;
            else       vld_q <= vld_d;
        end

        assign bus.valid_out = vld_q[S-1];
        assign bus.ready_in  = stg_load[0];
    end

    assign root          = lvl[LOGN][0];
    assign bus.found_out = root.found;
    assign bus.index_out = root.idx;
    assign bus.data_out  = root.data;
    assign fire_out      = bus.valid_out && bus.ready_out;

    // Pointer moves just past the winner on a delivered hit; in-flight requests keep theirs.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fire_out && bus.found_out) begin
            if (REVERSE != 0)
                rr_ptr_d = (bus.index_out == '0) ? LAST_LANE : bus.index_out - LOGN'(1);
            else
                rr_ptr_d = (bus.index_out == LAST_LANE) ? '0 : bus.index_out + LOGN'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_ptr_q <= PTR_RST;
        else       rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: tb/tb_vx_find_first_pipe.sv
// Bench for vx_find_first_pipe: four variants (fixed/rotating x ascending/descending)
// share one stimulus stream and are compared against a queue-based reference.
module tb_vx_find_first_pipe;
    localparam int N  = 8;
    localparam int DW = 8;
    localparam int S  = 3;
    localparam int ND = 4;

    typedef struct packed {
        logic          found;
        logic [2:0]    idx;
        logic [DW-1:0] data;
    } res_t;

    typedef struct packed {
        int               t;
        res_t [ND-1:0]    r;
    } ent_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   valid_in;
    logic                   ready_out;
    logic [N-1:0][DW-1:0]   data_in;
    logic [N-1:0]           mask_in;
    logic                   vo [ND];
    logic                   ri [ND];
    res_t                   got [ND];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   npop = 0;
    int   npush = 0;
    int   ptr_m [ND];
    ent_t q [$];
    res_t log_r2 [$];
    res_t log_r3 [$];

    always #5 clk = ~clk;

    // d: bit0 = REVERSE, bit1 = ROUND_ROBIN
    for (genvar g = 0; g < ND; g++) begin : g_dut
        vx_find_first_pipe_if #(.N(N), .DATAW(DW)) bus ();
        assign bus.valid_in  = valid_in;
        assign bus.data_in   = data_in;
        assign bus.mask_in   = mask_in;
        assign bus.ready_out = ready_out;
        assign ri[g]  = bus.ready_in;
        assign vo[g]  = bus.valid_out;
        assign got[g] = {bus.found_out, bus.index_out, bus.data_out};

        vx_find_first_pipe #(
            .N(N), .DATAW(DW), .REVERSE(g % 2), .ROUND_ROBIN(g / 2), .PIPE_EVERY(1)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic res_t ref_pick(input logic [N-1:0] m, input logic [N-1:0][DW-1:0] dat,
                                      input int p, input bit rev);
        res_t       r;
        logic [2:0] lane;
        r = '0;
        for (int j = 0; j < N; j++) begin
            lane = rev ? 3'((p - j + N) % N) : 3'((p + j) % N);
            if (m[lane] && !r.found) begin
                r.found = 1'b1;
                r.idx   = lane;
                r.data  = dat[lane];
            end
        end
        return r;
    endfunction

    function automatic int cur_ptr(input int d);
        if (d >= 2) return ptr_m[d];
        return (d % 2 == 1) ? N - 1 : 0;
    endfunction

    task automatic reset_model();
        q.delete();
        for (int d = 0; d < ND; d++) ptr_m[d] = (d % 2 == 1) ? N - 1 : 0;
    endtask

    // One cycle: sample just before the rising edge, advance the model, return at the falling edge.
    task automatic tick();
        bit   exp_rdy;
        bit   exp_vo;
        ent_t ne;
        ent_t he;
        #4;
        exp_rdy = ready_out || (q.size() < S);
        exp_vo  = 1'b0;
        if (q.size() > 0) exp_vo = (cyc - q[0].t) >= S;
        for (int d = 0; d < ND; d++) begin
            check_eq($sformatf("ready_in[%0d]", d), 32'(ri[d]), 32'(exp_rdy));
            check_eq($sformatf("valid_out[%0d]", d), 32'(vo[d]), 32'(exp_vo));
            if (exp_vo) check_eq($sformatf("result[%0d]", d), 32'(got[d]), 32'(q[0].r[d]));
        end
        if (valid_in && exp_rdy) begin
            ne.t = cyc;
            for (int d = 0; d < ND; d++) ne.r[d] = ref_pick(mask_in, data_in, cur_ptr(d), d % 2 == 1);
            q.push_back(ne);
            npush++;
        end
        if (exp_vo && ready_out) begin
            he = q.pop_front();
            npop++;
            log_r2.push_back(got[2]);
            log_r3.push_back(got[3]);
            for (int d = 2; d < ND; d++)
                if (he.r[d].found)
                    ptr_m[d] = (d % 2 == 1) ? (int'(he.r[d].idx) + N - 1) % N : (int'(he.r[d].idx) + 1) % N;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        valid_in  = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        check_eq("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic send(input logic [N-1:0] m);
        valid_in = 1'b1;
        mask_in  = m;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic lanes_x10();
        for (int i = 0; i < N; i++) data_in[i] = DW'(10 * i);
    endtask

    task automatic rand_input();
        case ($urandom_range(0, 3))
            0:       mask_in = '0;
            1:       mask_in = N'(1) << $urandom_range(0, N - 1);
            default: mask_in = N'($urandom);
        endcase
        for (int i = 0; i < N; i++) data_in[i] = DW'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        res_t x;
        int   base;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        mask_in   = '0;
        data_in   = '0;
        reset     = 1'b1;
        reset_model();

        // Reset state
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check_eq($sformatf("rst_valid_out[%0d]", d), 32'(vo[d]), 32'd0);
            check_eq($sformatf("rst_result[%0d]", d), 32'(got[d]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Rotating priority, one transaction in flight at a time
        lanes_x10();
        log_r2.delete(); log_r3.delete();
        for (int k = 0; k < 9; k++) begin
            send(8'hFF);
            drain();
        end
        check_eq("rr_single_count", 32'(log_r2.size()), 32'd9);
        for (int k = 0; k < 9 && k < log_r2.size(); k++) begin
            check_eq($sformatf("rr_fwd_idx[%0d]", k), 32'(log_r2[k].idx), 32'(k % N));
            check_eq($sformatf("rr_rev_idx[%0d]", k), 32'(log_r3[k].idx), 32'(N - 1 - k % N));
        end

        // Empty mask completes with zero result and leaves the pointer alone
        log_r2.delete(); log_r3.delete();
        send(8'h00);
        drain();
        send(8'hFF);
        drain();
        check_eq("empty_count", 32'(log_r2.size()), 32'd2);
        if (log_r2.size() == 2) begin
            check_eq("empty_fwd_res", 32'(log_r2[0]), 32'd0);
            check_eq("empty_rev_res", 32'(log_r3[0]), 32'd0);
            check_eq("after_empty_fwd_idx", 32'(log_r2[1].idx), 32'd1);
            check_eq("after_empty_rev_idx", 32'(log_r3[1].idx), 32'd6);
        end

        // Fixed priority, mask 0010_1100, latency S
        lanes_x10();
        send(8'h2C);
        tick();
        tick();
        x.found = 1'b1; x.idx = 3'd2; x.data = 8'd20;
        check_eq("fixed_fwd_valid", 32'(vo[0]), 32'd1);
        check_eq("fixed_fwd_res", 32'(got[0]), 32'(x));
        x.idx = 3'd5; x.data = 8'd50;
        check_eq("fixed_rev_res", 32'(got[1]), 32'(x));
        drain();

        // Back-to-back full-mask requests; captured-pointer lag checked by the model
        log_r2.delete();
        ready_out = 1'b1;
        valid_in  = 1'b1;
        for (int k = 0; k < 9; k++) begin
            mask_in = 8'hFF;
            tick();
        end
        drain();
        check_eq("rr_b2b_count", 32'(log_r2.size()), 32'd9);

        // Backpressure: 4 offered while the output is stalled for 5 cycles
        base      = npush;
        ready_out = 1'b0;
        for (int k = 0; k < 5; k++) begin
            valid_in = (npush - base) < 4;
            rand_input();
            tick();
        end
        check_eq("bp_ready_low", 32'(ri[0]), 32'd0);
        check_eq("bp_valid_held", 32'(vo[0]), 32'd1);
        base      = npop;
        ready_out = 1'b1;
        for (int k = 0; k < 10 && q.size() + npop - base < 4; k++) tick();
        valid_in = 1'b0;
        drain();
        check_eq("bp_delivered", 32'(npop - base), 32'd4);

        // Reset with 3 transactions in flight
        ready_out = 1'b0;
        valid_in  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mask_in = 8'hFF;
            tick();
        end
        valid_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            check_eq($sformatf("midrst_valid_out[%0d]", d), 32'(vo[d]), 32'd0);
            check_eq($sformatf("midrst_result[%0d]", d), 32'(got[d]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        reset_model();
        for (int k = 0; k < 4; k++) tick();
        log_r2.delete(); log_r3.delete();
        send(8'hFF);
        drain();
        check_eq("postrst_count", 32'(log_r2.size()), 32'd1);
        if (log_r2.size() == 1) begin
            check_eq("postrst_fwd_idx", 32'(log_r2[0].idx), 32'd0);
            check_eq("postrst_rev_idx", 32'(log_r3[0].idx), 32'd7);
        end

        // Random traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            valid_in  = ($urandom_range(0, 9) < 7);
            ready_out = ($urandom_range(0, 9) < 6);
            rand_input();
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
